// File: rtl/matmul_operand_loader_if.sv
// matmul_operand_loader_if
//   Bundles the element stream and the operand-presentation handshake of
//   matmul_operand_loader.
//   master : stream producer / operand consumer (drives in_valid, in_data,
//            in_last, out_ready)
//   slave  : the loader (drives in_ready, frame_err, out_valid, AI, BI)
//   Signals:
//     in_valid/in_ready/in_data/in_last : serial element stream, A then B
//     frame_err                         : one-cycle framing error pulse
//     out_valid/out_ready               : operand set handshake
//     AI/BI                             : packed A (M1_D1 x M1_D2), B (M1_D2 x M2_D2)
interface matmul_operand_loader_if #(
    parameter int bitlength = 8,
    parameter int M1_D1     = 3,
    parameter int M1_D2     = 4,
    parameter int M2_D2     = 2
);
    logic                               in_valid;
    logic                               in_ready;
    logic [bitlength-1:0]               in_data;
    logic                               in_last;
    logic                               frame_err;
    logic                               out_valid;
    logic                               out_ready;
    logic [M1_D1*M1_D2*bitlength-1:0]   AI;
    logic [M1_D2*M2_D2*bitlength-1:0]   BI;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, frame_err, out_valid, AI, BI
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, frame_err, out_valid, AI, BI
    );
endinterface

// File: rtl/matmul_operand_loader.sv
// matmul_operand_loader
//   Collects a frame of matrix elements (A row-major, then B row-major) from a
//   valid/ready stream and presents them as flat packed vectors AI/BI for a
//   combinational matrix multiplier, holding them until out_ready.
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     abort  : synchronous frame flush (only with MATMUL_LOADER_ABORT_EN)
//     bus    : matmul_operand_loader_if.slave (stream in, operands out)
//   Configuration macro: MATMUL_LOADER_ABORT_EN adds the abort input.
module matmul_operand_loader #(
    parameter int bitlength = 8,
    parameter int M1_D1     = 3,
    parameter int M1_D2     = 4,
    parameter int M2_D2     = 2
) (
    input  logic clk,
    input  logic rst_n,
`ifdef MATMUL_LOADER_ABORT_EN
    input  logic abort,
`endif
    matmul_operand_loader_if.slave bus
);
    localparam int NA    = M1_D1 * M1_D2;
    localparam int NB    = M1_D2 * M2_D2;
    localparam int MAXN  = (NA > NB) ? NA : NB;
    localparam int CNT_W = (MAXN > 1) ? $clog2(MAXN) : 1;
    localparam logic [CNT_W-1:0] NA_LAST = CNT_W'(NA - 1);
    localparam logic [CNT_W-1:0] NB_LAST = CNT_W'(NB - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        FULL   = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      out_valid_q, out_valid_d;
    logic                      frame_err_q, frame_err_d;
    logic [NA*bitlength-1:0]   ai_q, ai_d;
    logic [NB*bitlength-1:0]   bi_q, bi_d;
    logic                      wr_a, wr_b;
    logic                      abort_i;

`ifdef MATMUL_LOADER_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    // Stream is accepted whenever we are loading; in FULL the operands are
    // frozen and the handshake must complete first (no same-cycle bypass).
    assign bus.in_ready = (state_q != FULL);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        frame_err_d = 1'b0;
        wr_a        = 1'b0;
        wr_b        = 1'b0;
        if (abort_i) begin
            // Flush wins over everything; stored elements are left alone.
            state_d     = LOAD_A;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (bus.in_valid) begin
                        if (bus.in_last) begin
                            // Early end of frame: drop element, resync to A[0].
                            frame_err_d = 1'b1;
                            cnt_d       = '0;
                        end else begin
                            wr_a = 1'b1;
                            if (cnt_q == NA_LAST) begin
                                cnt_d   = '0;
                                state_d = LOAD_B;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    end
                end
                LOAD_B: begin
                    if (bus.in_valid) begin
                        if (cnt_q == NB_LAST) begin
                            // Final element: a missing in_last is flagged but the
                            // frame is still presented.
                            wr_b        = 1'b1;
                            cnt_d       = '0;
                            state_d     = FULL;
                            out_valid_d = 1'b1;
                            frame_err_d = ~bus.in_last;
                        end else if (bus.in_last) begin
                            frame_err_d = 1'b1;
                            cnt_d       = '0;
                            state_d     = LOAD_A;
                        end else begin
                            wr_b  = 1'b1;
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        state_d     = LOAD_A;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = LOAD_A;
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Per-element write enables decode the shared index counter.
    for (genvar gi = 0; gi < NA; gi++) begin : g_a
        assign ai_d[gi*bitlength +: bitlength] =
            (wr_a && (cnt_q == CNT_W'(gi))) ? bus.in_data
                                            : ai_q[gi*bitlength +: bitlength];
    end

    for (genvar gi = 0; gi < NB; gi++) begin : g_b
        assign bi_d[gi*bitlength +: bitlength] =
            (wr_b && (cnt_q == CNT_W'(gi))) ? bus.in_data
                                            : bi_q[gi*bitlength +: bitlength];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD_A;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            ai_q        <= '0;
            bi_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            ai_q        <= ai_d;
            bi_q        <= bi_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.AI        = ai_q;
    assign bus.BI        = bi_q;
endmodule
